// File: rtl/stacker_pkg.sv
// Shared definitions for the stack renderer.
//   - 2-bit colour codes used for stack levels and the falling block
//   - RGB332 output constants ({R[2:0], G[2:0], B[1:0]})
//   - coord_t: signed 12-bit coordinate, wide enough that no bound wraps
//   - code_to_rgb(): colour code -> RGB332
package stacker_pkg;

    localparam logic [1:0] CLR_NONE = 2'b00;
    localparam logic [1:0] CLR_GRN  = 2'b01;
    localparam logic [1:0] CLR_BLU  = 2'b10;
    localparam logic [1:0] CLR_RED  = 2'b11;

    localparam logic [7:0] RGB_BLACK = 8'h00;
    localparam logic [7:0] RGB_RED   = 8'hE0;   // 7/0/0
    localparam logic [7:0] RGB_GRN   = 8'h1C;   // 0/7/0
    localparam logic [7:0] RGB_BLU   = 8'h03;   // 0/0/3

    typedef logic signed [11:0] coord_t;

    function automatic logic [7:0] code_to_rgb(input logic [1:0] code);
        logic [7:0] rgb;
        case (code)
            CLR_GRN: rgb = RGB_GRN;
            CLR_BLU: rgb = RGB_BLU;
            CLR_RED: rgb = RGB_RED;
            default: rgb = RGB_BLACK;
        endcase
        return rgb;
    endfunction

endpackage

// File: rtl/rect_hit.sv
// Strict-bounds rectangle comparator.
//   i_en          : rectangle enabled (disabled rectangles never hit)
//   i_px, i_py    : pixel coordinate (signed 12-bit)
//   i_x0, i_x1    : horizontal bounds, hit when i_x0 < i_px < i_x1
//   i_y0, i_y1    : vertical bounds,   hit when i_y0 < i_py < i_y1
//   o_hit         : combinational hit flag
// Bounds may be negative; since pixel coordinates are never negative, any
// part of a rectangle above row 0 simply never matches.
module rect_hit
    import stacker_pkg::*;
(
    input  logic   i_en,
    input  coord_t i_px,
    input  coord_t i_py,
    input  coord_t i_x0,
    input  coord_t i_x1,
    input  coord_t i_y0,
    input  coord_t i_y1,
    output logic   o_hit
);

    assign o_hit = i_en
                && (i_px > i_x0) && (i_px < i_x1)
                && (i_py > i_y0) && (i_py < i_y1);

endmodule

// File: rtl/stack_renderer.sv
// Stack renderer: draws a stack of coloured blocks, its base and one falling
// block over a VGA raster.
//   dclk, rst_n        : pixel clock, asynchronous active-low reset
//   x, y               : current pixel coordinate
//   hs_in, vs_in       : active-low syncs accompanying x/y
//   pos_x, pos_y       : stack anchor
//   colors             : level i colour code at [2i+1:2i]
//   fall_x/fall_y/clr  : falling block position and colour code
//   land               : single-cycle landing pulse, starts the top-level flash
//   HS, VS             : syncs delayed by the 2-cycle pixel latency
//   RED, GREEN, BLUE   : registered RGB332 pixel
// All scene inputs are shadowed on the vs_in falling edge so a frame is drawn
// from one consistent snapshot.
module stack_renderer
    import stacker_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int BLK_W    = 100,
    parameter int BLK_H    = 20,
    parameter int FLASH_FR = 30
) (
    input  logic               dclk,
    input  logic               rst_n,
    input  logic [9:0]         x,
    input  logic [9:0]         y,
    input  logic               hs_in,
    input  logic               vs_in,
    input  logic [9:0]         pos_x,
    input  logic [9:0]         pos_y,
    input  logic [2*DEPTH-1:0] colors,
    input  logic [9:0]         fall_x,
    input  logic [9:0]         fall_y,
    input  logic [1:0]         fall_clr,
    input  logic               land,
    output logic               HS,
    output logic               VS,
    output logic [2:0]         RED,
    output logic [2:0]         GREEN,
    output logic [1:0]         BLUE
);

    // Counter needs bit 2 for the blink even when FLASH_FR is tiny.
    localparam int FW = ($clog2(FLASH_FR + 1) < 3) ? 3 : $clog2(FLASH_FR + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam coord_t BLK_W_C  = coord_t'(BLK_W);
    localparam coord_t BLK_H_C  = coord_t'(BLK_H);
    localparam coord_t BLK_H2_C = coord_t'(2 * BLK_H);

    // Frame registers
    logic [9:0]         r_pos_x, r_pos_y, r_fall_x, r_fall_y;
    logic [2*DEPTH-1:0] r_colors;
    logic [1:0]         r_fall_clr;
    logic [FW-1:0]      r_flash;

    // Stage 1
    logic [9:0] r_x, r_y;
    logic       r_hs1, r_vs1;

    // Stage 2
    logic [7:0] r_rgb;
    logic       r_hs2, r_vs2;

    // r_vs1 is last cycle's vs_in, so it doubles as the edge detector.
    logic w_frame_latch;
    assign w_frame_latch = r_vs1 & ~vs_in;

    always_ff @(posedge dclk or negedge rst_n) begin
        if (!rst_n) begin
            r_pos_x    <= '0;
            r_pos_y    <= '0;
            r_colors   <= '0;
            r_fall_x   <= '0;
            r_fall_y   <= '0;
            r_fall_clr <= '0;
        end else if (w_frame_latch) begin
            r_pos_x    <= pos_x;
            r_pos_y    <= pos_y;
            r_colors   <= colors;
            r_fall_x   <= fall_x;
            r_fall_y   <= fall_y;
            r_fall_clr <= fall_clr;
        end
    end

    // A landing always wins over the per-frame decrement.
    always_ff @(posedge dclk or negedge rst_n) begin
        if (!rst_n) begin
            r_flash <= '0;
        end else if (land) begin
            r_flash <= FW'(FLASH_FR);
        end else if (w_frame_latch && (r_flash != '0)) begin
            r_flash <= r_flash - FW'(1);
        end
    end

    always_ff @(posedge dclk or negedge rst_n) begin
        if (!rst_n) begin
            r_x   <= '0;
            r_y   <= '0;
            r_hs1 <= 1'b1;
            r_vs1 <= 1'b1;
        end else begin
            r_x   <= x;
            r_y   <= y;
            r_hs1 <= hs_in;
            r_vs1 <= vs_in;
        end
    end

    // Geometry (signed 12-bit)
    coord_t w_px, w_py, w_sx_lo, w_sx_hi, w_sy, w_fx_lo, w_fx_hi, w_fy_lo, w_fy_hi;
    assign w_px    = coord_t'({2'b00, r_x});
    assign w_py    = coord_t'({2'b00, r_y});
    assign w_sx_lo = coord_t'({2'b00, r_pos_x});
    assign w_sx_hi = w_sx_lo + BLK_W_C;
    assign w_sy    = coord_t'({2'b00, r_pos_y});
    assign w_fx_lo = coord_t'({2'b00, r_fall_x});
    assign w_fx_hi = w_fx_lo + BLK_W_C;
    assign w_fy_lo = coord_t'({2'b00, r_fall_y});
    assign w_fy_hi = w_fy_lo + BLK_H_C;

    logic [DEPTH-1:0] w_lvl_hit;
    logic             w_base_hit, w_fall_hit;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_lvl
            // Level gi spans (pos_y - gi*H, pos_y - (gi-1)*H); level 0 sits just below pos_y.
            localparam coord_t LO_OFF = coord_t'(gi * BLK_H);
            localparam coord_t HI_OFF = coord_t'((gi - 1) * BLK_H);
            rect_hit u_hit (
                .i_en (r_colors[2*gi+1:2*gi] != CLR_NONE),
                .i_px (w_px),
                .i_py (w_py),
                .i_x0 (w_sx_lo),
                .i_x1 (w_sx_hi),
                .i_y0 (w_sy - LO_OFF),
                .i_y1 (w_sy - HI_OFF),
                .o_hit(w_lvl_hit[gi])
            );
        end
    endgenerate

    rect_hit u_base (
        .i_en (1'b1),
        .i_px (w_px),
        .i_py (w_py),
        .i_x0 (w_sx_lo),
        .i_x1 (w_sx_hi),
        .i_y0 (w_sy + BLK_H_C),
        .i_y1 (w_sy + BLK_H2_C),
        .o_hit(w_base_hit)
    );

    rect_hit u_fall (
        .i_en (r_fall_clr != CLR_NONE),
        .i_px (w_px),
        .i_py (w_py),
        .i_x0 (w_fx_lo),
        .i_x1 (w_fx_hi),
        .i_y0 (w_fy_lo),
        .i_y1 (w_fy_hi),
        .o_hit(w_fall_hit)
    );

    // Top level: highest index with a non-empty code.
    logic [IW-1:0] w_top_idx;
    logic          w_top_vld;
    always_comb begin
        w_top_idx = '0;
        w_top_vld = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_colors[2*i +: 2] != CLR_NONE) begin
                w_top_idx = IW'(i);
                w_top_vld = 1'b1;
            end
        end
    end

    // Hit level selection: scan downwards so the lowest hit index is kept.
    logic [IW-1:0] w_lvl_idx;
    logic [1:0]    w_lvl_code;
    logic          w_lvl_any;
    always_comb begin
        w_lvl_idx  = '0;
        w_lvl_code = CLR_NONE;
        w_lvl_any  = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (w_lvl_hit[i]) begin
                w_lvl_idx  = IW'(i);
                w_lvl_code = r_colors[2*i +: 2];
                w_lvl_any  = 1'b1;
            end
        end
    end

    logic w_blink_off;
    assign w_blink_off = (r_flash != '0) && r_flash[2];

    logic [7:0] w_rgb_next;
    always_comb begin
        w_rgb_next = RGB_BLACK;
        if (w_fall_hit) begin
            w_rgb_next = code_to_rgb(r_fall_clr);
        end else if (w_lvl_any) begin
            if (w_blink_off && w_top_vld && (w_lvl_idx == w_top_idx)) begin
                w_rgb_next = RGB_BLACK;
            end else begin
                w_rgb_next = code_to_rgb(w_lvl_code);
            end
        end else if (w_base_hit) begin
            w_rgb_next = RGB_GRN;
        end
    end

    always_ff @(posedge dclk or negedge rst_n) begin
        if (!rst_n) begin
            r_rgb <= RGB_BLACK;
            r_hs2 <= 1'b1;
            r_vs2 <= 1'b1;
        end else begin
            r_rgb <= w_rgb_next;
            r_hs2 <= r_hs1;
            r_vs2 <= r_vs1;
        end
    end

    assign RED   = r_rgb[7:5];
    assign GREEN = r_rgb[4:2];
    assign BLUE  = r_rgb[1:0];
    assign HS    = r_hs2;
    assign VS    = r_vs2;

endmodule
